// File: rtl/variable_node_unit.sv
// Variable node PE of the LDPC decoder: holds one channel LLR, sums it with
// DV check messages and returns per-edge extrinsic messages through a
// two-stage pipeline, counting iterations until MAX_ITER is reached.
// With USE_PHI=1 the 4-bit output magnitude is round(4*phi(m/4)), where
// phi(x) = -ln(tanh(x/2)) and m = min(|ext|,63); phi(0) saturates to 15.
module variable_node_unit #(
    parameter int unsigned DV       = 3,
    parameter int unsigned MAX_ITER = 8,
    parameter int unsigned USE_PHI  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4:0]          llr_in,
    input  logic [DV-1:0][4:0]  Y,
    output logic [DV-1:0][5:0]  X,
    output logic                hd,
    output logic [7:0]          iter_cnt,
    output logic                done
);

    localparam int unsigned SW = $clog2(15 * (DV + 1)) + 2;

    // sign-magnitude to two's complement; -0 maps to 0
    function automatic logic signed [SW-1:0] sm_to_tc(input logic [4:0] v);
        logic signed [SW-1:0] m;
        m = SW'(v[3:0]);
        return v[4] ? -m : m;
    endfunction

    // quantised phi table, 6-bit magnitude in, 4-bit magnitude out
    function automatic logic [3:0] phi_lut(input logic [5:0] m);
        logic [3:0] r;
        case (m)
            6'd0:    r = 4'd15;
            6'd1:    r = 4'd8;
            6'd2:    r = 4'd6;
            6'd3:    r = 4'd4;
            6'd4:    r = 4'd3;
            6'd5,
            6'd6:    r = 4'd2;
            6'd7,
            6'd8,
            6'd9,
            6'd10,
            6'd11:   r = 4'd1;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    logic [4:0]           llr_reg;
    logic                 v1;
    logic signed [SW-1:0] y_c     [DV];
    logic signed [SW-1:0] y_r     [DV];
    logic signed [SW-1:0] total_c;
    logic signed [SW-1:0] total_r;
    logic [DV-1:0][5:0]   x_c;
    logic                 hd_c;
    logic [7:0]           iter_nxt;

    // stage-1 datapath: convert check messages and form the node total
    always_comb begin
        total_c = sm_to_tc(llr_reg);
        for (int i = 0; i < DV; i++) begin
            y_c[i]  = sm_to_tc(Y[i]);
            total_c = total_c + y_c[i];
        end
    end

    // stage-2 datapath: extrinsic value, sign and saturated/LUT magnitude per edge
    always_comb begin
        logic signed [SW-1:0] ext;
        logic [SW-1:0]        abs_v;
        logic [3:0]           mag;
        hd_c = (total_r < 0);
        x_c  = '0;
        for (int i = 0; i < DV; i++) begin
            ext   = total_r - y_r[i];
            abs_v = (ext < 0) ? SW'(-ext) : SW'(ext);
            if (USE_PHI != 0)
                mag = phi_lut((abs_v > SW'(63)) ? 6'd63 : abs_v[5:0]);
            else
                mag = (abs_v > SW'(15)) ? 4'hF : abs_v[3:0];
            x_c[i] = {hd_c, (ext < 0), mag};
        end
        iter_nxt = (iter_cnt == 8'hFF) ? iter_cnt : iter_cnt + 8'd1;
    end

    // pipeline, iteration counter and done flag; load restarts, done freezes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llr_reg  <= '0;
            v1       <= 1'b0;
            total_r  <= '0;
            for (int i = 0; i < DV; i++) y_r[i] <= '0;
            X        <= '0;
            hd       <= 1'b0;
            iter_cnt <= '0;
            done     <= 1'b0;
        end else if (load) begin
            llr_reg  <= llr_in;
            v1       <= 1'b0;
            X        <= '0;
            hd       <= 1'b0;
            iter_cnt <= '0;
            done     <= 1'b0;
        end else if (en && !done) begin
            for (int i = 0; i < DV; i++) y_r[i] <= y_c[i];
            total_r <= total_c;
            v1      <= 1'b1;
            if (v1) begin
                X        <= x_c;
                hd       <= hd_c;
                iter_cnt <= iter_nxt;
                done     <= (iter_nxt == 8'(MAX_ITER));
            end
        end
    end

endmodule

// File: tb/tb_variable_node_unit.sv
// Directed bench for variable_node_unit (DV=3, MAX_ITER=4): one instance with
// saturating magnitude, one with the phi LUT, sharing all inputs.
module tb_variable_node_unit;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [4:0]       llr_in;
    logic [2:0][4:0]  y;
    logic [2:0][5:0]  x_sat, x_phi;
    logic             hd_sat, hd_phi;
    logic [7:0]       it_sat, it_phi;
    logic             done_sat, done_phi;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    variable_node_unit #(.DV(3), .MAX_ITER(4), .USE_PHI(0)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .llr_in(llr_in), .Y(y),
        .X(x_sat), .hd(hd_sat), .iter_cnt(it_sat), .done(done_sat)
    );

    variable_node_unit #(.DV(3), .MAX_ITER(4), .USE_PHI(1)) dut_phi (
        .clk(clk), .rst(rst), .en(en), .load(load), .llr_in(llr_in), .Y(y),
        .X(x_phi), .hd(hd_phi), .iter_cnt(it_phi), .done(done_phi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // one clock: inputs applied at the falling edge, outputs sampled at the next one
    task automatic cycle(input logic en_v, input logic load_v);
        en   = en_v;
        load = load_v;
        @(posedge clk);
        @(negedge clk);
    endtask

    // load llr, then two enabled edges with y held
    task automatic run_vec(input logic [4:0] l, input logic [4:0] y0, input logic [4:0] y1,
                           input logic [4:0] y2);
        llr_in = l;
        y[0] = y0; y[1] = y1; y[2] = y2;
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        en = 1'b0;
    endtask

    function automatic int sm(input logic [4:0] v);
        return v[4] ? -int'(v[3:0]) : int'(v[3:0]);
    endfunction

    function automatic logic [3:0] lut_model(input int m);
        if (m == 0)  return 4'd15;
        if (m == 1)  return 4'd8;
        if (m == 2)  return 4'd6;
        if (m == 3)  return 4'd4;
        if (m == 4)  return 4'd3;
        if (m <= 6)  return 4'd2;
        if (m <= 11) return 4'd1;
        return 4'd0;
    endfunction

    function automatic logic [17:0] model_x(input logic [4:0] l, input logic [4:0] y0,
                                            input logic [4:0] y1, input logic [4:0] y2,
                                            input bit phi);
        int ys[3];
        int tot, e, a;
        logic [17:0] r;
        logic [3:0] m;
        ys[0] = sm(y0); ys[1] = sm(y1); ys[2] = sm(y2);
        tot = sm(l) + ys[0] + ys[1] + ys[2];
        r = '0;
        for (int i = 0; i < 3; i++) begin
            e = tot - ys[i];
            a = (e < 0) ? -e : e;
            if (phi) m = lut_model((a > 63) ? 63 : a);
            else     m = (a > 15) ? 4'd15 : 4'(a);
            r[i*6 +: 6] = {tot < 0, e < 0, m};
        end
        return r;
    endfunction

    initial begin
        logic [17:0] x2;
        int a, s;
        logic [4:0] l, y1v, y2v, y0v;

        rst = 1'b1; en = 1'b0; load = 1'b0; llr_in = '0; y = '0;
        @(negedge clk);
        check("reset_x", 32'(x_sat), 32'h0);
        check("reset_hd_iter_done", {hd_sat, it_sat, done_sat}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // test 1: reset asserted mid-pipeline clears outputs before the next edge
        run_vec(5'b00101, 5'b00011, 5'b10010, 5'b00100);
        en = 1'b1;
        cycle(1'b1, 1'b0);
        check("pre_rst_iter", 32'(it_sat), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_x", 32'(x_sat), 32'h0);
        check("async_rst_state", {hd_sat, it_sat, done_sat}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0);
        check("post_rst_no_partial_x", 32'(x_sat), 32'h0);
        check("post_rst_iter", 32'(it_sat), 32'd0);
        en = 1'b0;

        // test 2
        x2 = {6'b000110, 6'b001100, 6'b000111};
        run_vec(5'b00101, 5'b00011, 5'b10010, 5'b00100);
        check("t2_x", 32'(x_sat), 32'(x2));
        check("t2_hd", 32'(hd_sat), 32'd0);
        check("t2_iter", 32'(it_sat), 32'd1);
        check("t2_phi_x", 32'(x_phi), 32'({6'b000010, 6'b000000, 6'b000001}));

        // test 3: saturation
        run_vec(5'b01111, 5'b01111, 5'b01111, 5'b01111);
        check("t3_x", 32'(x_sat), 32'({3{6'b001111}}));
        check("t3_phi_x", 32'(x_phi), 32'h0);

        // test 4: negative total
        run_vec(5'b11001, 5'b00010, 5'b10011, 5'b00001);
        check("t4_x", 32'(x_sat), 32'({6'b111010, 6'b110110, 6'b111011}));
        check("t4_hd", 32'(hd_sat), 32'd1);

        // test 5: -0 handling and zero total
        run_vec(5'b10000, 5'b00100, 5'b10100, 5'b10000);
        check("t5_x", 32'(x_sat), 32'({6'b000000, 6'b000100, 6'b010100}));
        check("t5_hd", 32'(hd_sat), 32'd0);

        // test 6: iteration count and done with en held high
        llr_in = 5'b00101;
        y[0] = 5'b00011; y[1] = 5'b10010; y[2] = 5'b00100;
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        check("t6_iter_e1", 32'(it_sat), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            cycle(1'b1, 1'b0);
            check($sformatf("t6_iter_e%0d", k), 32'(it_sat), 32'(k - 1));
            check($sformatf("t6_done_e%0d", k), 32'(done_sat), (k == 5) ? 32'd1 : 32'd0);
        end
        y = {3{5'b01111}};
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("t6_frozen_x", 32'(x_sat), 32'(x2));
        check("t6_frozen_iter", 32'(it_sat), 32'd4);
        check("t6_frozen_done", 32'(done_sat), 32'd1);
        cycle(1'b1, 1'b1);
        check("t6_load_clears", {x_sat, it_sat, done_sat}, 32'h0);

        // en toggling: test 2 delivered after two enabled edges, y ignored while en=0
        llr_in = 5'b00101;
        cycle(1'b0, 1'b1);
        y[0] = 5'b00011; y[1] = 5'b10010; y[2] = 5'b00100;
        cycle(1'b1, 1'b0);
        y = {3{5'b11111}};
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("tog_not_yet_x", 32'(x_sat), 32'h0);
        y[0] = 5'b00011; y[1] = 5'b10010; y[2] = 5'b00100;
        cycle(1'b1, 1'b0);
        check("tog_x", 32'(x_sat), 32'(x2));
        check("tog_iter", 32'(it_sat), 32'd1);
        y = {3{5'b11111}};
        cycle(1'b0, 1'b0);
        check("tog_hold_x", 32'(x_sat), 32'(x2));

        // phi sweep: ext[0] walks -45..45, other edges follow from the model
        for (int t = -45; t <= 45; t++) begin
            a = (t < 0) ? -t : t;
            s = (t < 0) ? 1 : 0;
            l   = {1'(s), 4'((a > 15) ? 15 : a)};
            y1v = {1'(s), 4'((a > 30) ? 15 : ((a > 15) ? a - 15 : 0))};
            y2v = {1'(s), 4'((a > 30) ? a - 30 : 0)};
            y0v = 5'((a * 7) % 32);
            run_vec(l, y0v, y1v, y2v);
            check($sformatf("sweep_phi_%0d", t), 32'(x_phi), 32'(model_x(l, y0v, y1v, y2v, 1'b1)));
            check($sformatf("sweep_sat_%0d", t), 32'(x_sat), 32'(model_x(l, y0v, y1v, y2v, 1'b0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
